running_max: RTL and testbench
==============================

RUNNING_MAX -- requirements
Module: running_max

Interface
REQ-001 Parameter WIDTH, default 4: sample width in bits; legal range >= 1.
REQ-002 Parameter WINDOW, default 8: samples per result; legal range >= 2.
REQ-003 Parameter SIGNED, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  in_data holds a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  WIDTH  sample value.
REQ-009 flush  input  1  close the current window early.
REQ-010 out_valid  output  1  result is available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_max  output  WIDTH  maximum of the window.
REQ-013 out_count  output  $clog2(WINDOW+1)  number of samples in the window.
REQ-014 out_idx  output  $clog2(WINDOW)  window position of the maximum; present only per REQ-032.

Function
REQ-015 The FSM shall have two states: ACCUM and HOLD.
REQ-016 In ACCUM, in_ready shall be 1 and out_valid 0; in HOLD, in_ready shall be 0 and out_valid 1.
REQ-017 A sample shall be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-018 The first accepted sample of a window shall load the max register unconditionally.
REQ-019 Each later accepted sample shall replace the max only if it is strictly greater under the SIGNED rule; a tie keeps the earlier value.
REQ-020 The count shall increment on each accepted sample.
REQ-021 Accepting the WINDOW-th sample shall move ACCUM to HOLD on the same edge, so out_valid is high the next cycle with the final values.
REQ-022 Flush in ACCUM with count > 0 and no accepted sample shall move to HOLD with the partial result.
REQ-023 Flush on the same cycle as an accepted sample shall include that sample, then move to HOLD.
REQ-024 Flush in ACCUM with count == 0 and no accepted sample shall be ignored.
REQ-025 Flush in HOLD shall be ignored.
REQ-026 In HOLD, out_max, out_count and out_idx shall remain stable until out_valid && out_ready.
REQ-027 On out_valid && out_ready, the FSM shall return to ACCUM and clear the count.
REQ-028 The next sample is accepted one cycle after REQ-027 (no bypass); sustained throughput is therefore WINDOW samples per WINDOW+1 cycles.
REQ-029 Comparison shall use WIDTH bits only, with no overflow or extension artefacts; with SIGNED=1, the most negative value shall be the minimum.

Reset
REQ-030 On a rising edge with rst_n==0, the block shall enter ACCUM and set count, max register and index to 0.
REQ-031 Reset shall take priority over every other input; a partially accumulated window or a held result is discarded without being emitted. out_valid is 0 and in_ready 1 on the cycle after reset.

Configuration
REQ-032 Macro RUNNING_MAX_IDX_EN:
- Defined: port out_idx exists. It records the 0-based position within the window of the first occurrence of the maximum, updated with the max per REQ-018/019.
- Undefined: port out_idx and its register are absent; all other behaviour is identical.

Verification
REQ-033 WIDTH=4, WINDOW=4, SIGNED=0; samples 0110, 0111, 1000, 0011 back-to-back -> out_valid next cycle; out_max=1000, out_count=4, out_idx=2.
REQ-034 Tie case, same parameters; samples 1010, 1010, 0001, 0000 -> out_max=1010, out_idx=0.
REQ-035 SIGNED=1; samples 1111, 0001, 1000, 0000 -> out_max=0001, out_idx=1.
REQ-036 Flush paths:
- Samples 0011, 0101, then flush with in_valid=0 -> out_max=0101, out_count=2.
- Flush with count==0 -> out_valid stays 0.
REQ-037 Backpressure and reset:
- Hold out_ready=0 for 3 cycles after out_valid -> out_valid, out_max and out_count stable, and in_ready=0 throughout; the first sample is accepted the cycle after out_ready=1.
- Assert rst_n=0 after 2 samples -> no result emitted; the next full window starts at count 0.

Source files
------------

// File: rtl/running_max_if.sv
// Handshake bundle for running_max: a sample stream in, a windowed maximum out.
// Build option: define RUNNING_MAX_IDX_EN to add out_idx, the position of the maximum.
// The WIDTH and WINDOW given here must match the parameters of the running_max it serves.
interface running_max_if #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8
);

  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0]               in_data;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               out_max;
  logic [$clog2(WINDOW+1)-1:0]    out_count;
`ifdef RUNNING_MAX_IDX_EN
  logic [$clog2(WINDOW)-1:0]      out_idx;
`endif

`ifdef RUNNING_MAX_IDX_EN
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_max, out_count, out_idx
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_max, out_count, out_idx
  );
`else
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_max, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_max, out_count
  );
`endif

endinterface

// File: rtl/running_max.sv
// running_max: collects up to WINDOW samples, then presents their maximum and count
// until the consumer takes it. A flush closes a non-empty window early.
// Build option: define RUNNING_MAX_IDX_EN to also report out_idx, the 0-based
// position of the first occurrence of the maximum inside the window.
module running_max #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8,
  parameter int SIGNED = 0
) (
  input logic         clk,
  input logic         rst_n,
  running_max_if.slave bus
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int IW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] max_q;
  logic             greater;
  logic             accept;
  logic             take;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             release_c;

  // Strict greater-than between the incoming sample and the current max, in WIDTH bits
  always_comb begin
    greater = 1'b0;
    if (SIGNED != 0) begin
      greater = $signed(bus.in_data) > $signed(max_q);
    end else begin
      greater = bus.in_data > max_q;
    end
  end

  // Next state, handshake outputs and the accept/update strobes for the datapath
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    take        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    release_c   = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        take       = accept && ((count_q == '0) || greater);
        if (accept && ((count_q == LAST) || bus.flush)) begin
          state_d = HOLD;
        end else if (!accept && bus.flush && (count_q != '0)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid_c = 1'b1;
        release_c   = bus.out_ready;
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State register; reset discards whatever window is open or held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Count and max: the first sample of a window loads unconditionally, later ones only if larger
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      max_q   <= '0;
    end else if (accept) begin
      count_q <= count_q + CW'(1);
      if (take) begin
        max_q <= bus.in_data;
      end
    end else if (release_c) begin
      count_q <= '0;
    end
  end

`ifdef RUNNING_MAX_IDX_EN
  logic [IW-1:0] idx_q;

  // Position of the max follows the max update; the pre-increment count is the sample's position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (take) begin
      idx_q <= count_q[IW-1:0];
    end
  end

  assign bus.out_idx = idx_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = max_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_running_max.sv
// Directed bench for running_max with WIDTH=4, WINDOW=4: an unsigned instance
// and a signed instance share clock and reset. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_running_max;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  running_max_if #(.WIDTH(4), .WINDOW(4)) bus_u ();
  running_max_if #(.WIDTH(4), .WINDOW(4)) bus_s ();

  running_max #(.WIDTH(4), .WINDOW(4), .SIGNED(0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u)
  );

  running_max #(.WIDTH(4), .WINDOW(4), .SIGNED(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_u.in_valid = 1'b0; bus_u.in_data = 4'd0; bus_u.flush = 1'b0; bus_u.out_ready = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_data = 4'd0; bus_s.flush = 1'b0; bus_s.out_ready = 1'b0;
  endtask

  task automatic push_u(input logic [3:0] d);
    bus_u.in_valid = 1'b1;
    bus_u.in_data  = d;
    step();
    bus_u.in_valid = 1'b0;
  endtask

  task automatic push_s(input logic [3:0] d);
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = d;
    step();
    bus_s.in_valid = 1'b0;
  endtask

  task automatic consume_u();
    bus_u.out_ready = 1'b1;
    step();
    bus_u.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (bus_u.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: observed %0d expected 1", bus_u.in_ready); end
    checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: observed %0d expected 0", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: observed %0d expected 0", bus_u.out_count); end
    checks++; if (bus_u.out_max !== 4'd0) begin failures++; $display("[TB] FAIL reset_max: observed %0d expected 0", bus_u.out_max); end
    checks++; if (bus_s.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_out_valid: observed %0d expected 0", bus_s.out_valid); end
  endtask

  task automatic test_window();
    logic [3:0] samples [4] = '{4'b0110, 4'b0111, 4'b1000, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      push_u(samples[i]);
      if (i < 3) begin
        checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL window_early_valid: observed %0d expected 0 after sample %0d", bus_u.out_valid, i); end
      end
    end
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL window_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_max !== 4'b1000) begin failures++; $display("[TB] FAIL window_max: observed %0d expected 8", bus_u.out_max); end
    checks++; if (bus_u.out_count !== 3'd4) begin failures++; $display("[TB] FAIL window_count: observed %0d expected 4", bus_u.out_count); end
`ifdef RUNNING_MAX_IDX_EN
    checks++; if (bus_u.out_idx !== 2'd2) begin failures++; $display("[TB] FAIL window_idx: observed %0d expected 2", bus_u.out_idx); end
`endif
    consume_u();
    checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL window_release: observed %0d expected 0", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd0) begin failures++; $display("[TB] FAIL window_count_clear: observed %0d expected 0", bus_u.out_count); end
  endtask

  task automatic test_tie();
    logic [3:0] samples [4] = '{4'b1010, 4'b1010, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) push_u(samples[i]);
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL tie_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_max !== 4'b1010) begin failures++; $display("[TB] FAIL tie_max: observed %0d expected 10", bus_u.out_max); end
`ifdef RUNNING_MAX_IDX_EN
    checks++; if (bus_u.out_idx !== 2'd0) begin failures++; $display("[TB] FAIL tie_idx: observed %0d expected 0", bus_u.out_idx); end
`endif
    consume_u();
  endtask

  task automatic test_signed();
    logic [3:0] samples [4] = '{4'b1111, 4'b0001, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) push_s(samples[i]);
    checks++; if (bus_s.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL signed_valid: observed %0d expected 1", bus_s.out_valid); end
    checks++; if (bus_s.out_max !== 4'b0001) begin failures++; $display("[TB] FAIL signed_max: observed %0d expected 1", bus_s.out_max); end
    checks++; if (bus_s.out_count !== 3'd4) begin failures++; $display("[TB] FAIL signed_count: observed %0d expected 4", bus_s.out_count); end
`ifdef RUNNING_MAX_IDX_EN
    checks++; if (bus_s.out_idx !== 2'd1) begin failures++; $display("[TB] FAIL signed_idx: observed %0d expected 1", bus_s.out_idx); end
`endif
    bus_s.out_ready = 1'b1;
    step();
    bus_s.out_ready = 1'b0;
    checks++; if (bus_s.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL signed_release: observed %0d expected 0", bus_s.out_valid); end
  endtask

  task automatic test_flush();
    push_u(4'b0011);
    push_u(4'b0101);
    bus_u.flush = 1'b1;
    step();
    bus_u.flush = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_max !== 4'b0101) begin failures++; $display("[TB] FAIL flush_max: observed %0d expected 5", bus_u.out_max); end
    checks++; if (bus_u.out_count !== 3'd2) begin failures++; $display("[TB] FAIL flush_count: observed %0d expected 2", bus_u.out_count); end
    bus_u.flush = 1'b1;
    step();
    bus_u.flush = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_hold_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd2) begin failures++; $display("[TB] FAIL flush_hold_count: observed %0d expected 2", bus_u.out_count); end
    consume_u();
    bus_u.flush = 1'b1;
    step();
    bus_u.flush = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_empty_valid: observed %0d expected 0", bus_u.out_valid); end
    checks++; if (bus_u.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty_ready: observed %0d expected 1", bus_u.in_ready); end
    bus_u.flush = 1'b1;
    push_u(4'b0010);
    bus_u.flush = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_with_sample_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd1) begin failures++; $display("[TB] FAIL flush_with_sample_count: observed %0d expected 1", bus_u.out_count); end
    checks++; if (bus_u.out_max !== 4'b0010) begin failures++; $display("[TB] FAIL flush_with_sample_max: observed %0d expected 2", bus_u.out_max); end
    consume_u();
  endtask

  task automatic test_back_to_back();
    push_u(4'd1);
    push_u(4'd2);
    push_u(4'd3);
    push_u(4'd4);
    bus_u.in_valid = 1'b1;
    bus_u.in_data  = 4'd15;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid: observed %0d expected 1 at cycle %0d", bus_u.out_valid, i); end
      checks++; if (bus_u.out_max !== 4'd4) begin failures++; $display("[TB] FAIL bp_max: observed %0d expected 4 at cycle %0d", bus_u.out_max, i); end
      checks++; if (bus_u.out_count !== 3'd4) begin failures++; $display("[TB] FAIL bp_count: observed %0d expected 4 at cycle %0d", bus_u.out_count, i); end
      checks++; if (bus_u.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready: observed %0d expected 0 at cycle %0d", bus_u.in_ready, i); end
    end
    bus_u.in_data   = 4'd9;
    bus_u.out_ready = 1'b1;
    step();
    bus_u.out_ready = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid: observed %0d expected 0", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd0) begin failures++; $display("[TB] FAIL bp_no_bypass_count: observed %0d expected 0", bus_u.out_count); end
    step();
    checks++; if (bus_u.out_count !== 3'd1) begin failures++; $display("[TB] FAIL bp_first_accept_count: observed %0d expected 1", bus_u.out_count); end
    bus_u.in_data = 4'd1;
    step();
    step();
    step();
    bus_u.in_valid = 1'b0;
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_max !== 4'd9) begin failures++; $display("[TB] FAIL bp_next_max: observed %0d expected 9", bus_u.out_max); end
    checks++; if (bus_u.out_count !== 3'd4) begin failures++; $display("[TB] FAIL bp_next_count: observed %0d expected 4", bus_u.out_count); end
    consume_u();
  endtask

  task automatic test_reset_mid();
    logic [3:0] samples [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
    push_u(4'd7);
    push_u(4'd8);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid: observed %0d expected 0", bus_u.out_valid); end
    checks++; if (bus_u.out_count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_count: observed %0d expected 0", bus_u.out_count); end
    checks++; if (bus_u.out_max !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_max: observed %0d expected 0", bus_u.out_max); end
    for (int i = 0; i < 4; i++) begin
      push_u(samples[i]);
      if (i < 3) begin
        checks++; if (bus_u.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_early_valid: observed %0d expected 0 after sample %0d", bus_u.out_valid, i); end
      end
    end
    checks++; if (bus_u.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_full_valid: observed %0d expected 1", bus_u.out_valid); end
    checks++; if (bus_u.out_max !== 4'd3) begin failures++; $display("[TB] FAIL rstmid_full_max: observed %0d expected 3", bus_u.out_max); end
    checks++; if (bus_u.out_count !== 3'd4) begin failures++; $display("[TB] FAIL rstmid_full_count: observed %0d expected 4", bus_u.out_count); end
`ifdef RUNNING_MAX_IDX_EN
    checks++; if (bus_u.out_idx !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_full_idx: observed %0d expected 0", bus_u.out_idx); end
`endif
    consume_u();
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    idle_inputs();
    test_reset();
    test_window();
    test_tie();
    test_signed();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
